// File: rtl/bit_serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package bit_serial_adder_pkg;

  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {IDLE, RUN, DONE} bsa_state_t;

endpackage

// File: rtl/bit_serial_adder_fa_cell.sv
// One-bit full adder built from two half-add terms and an OR.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ab_x;

  assign ab_x = a ^ b;
  assign s    = ab_x ^ cin;
  assign cout = (a & b) | (ab_x & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: LSB-first, one bit per clock through a single full-adder cell.
// Handshakes: a transfer happens on a rising clk edge where valid && ready are both high.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             busy
);

  localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  bsa_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             s_bit, c_next;
  logic             accept, last_bit;

  fa_cell u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry_q),
    .s   (s_bit),
    .cout(c_next)
  );

  assign accept   = (state_q == IDLE) && in_valid;
  assign last_bit = (state_q == RUN) && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The completed word is the shifted result with this cycle's sum bit at the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      out_sum   <= '0;
      out_carry <= 1'b0;
    end else if (accept) begin
      a_sh    <= in_a;
      b_sh    <= in_b;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else if (state_q == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      carry_q <= c_next;
      res_sh  <= {s_bit, res_sh[WIDTH-1:1]};
      if (last_bit) begin
        out_sum   <= {s_bit, res_sh[WIDTH-1:1]};
        out_carry <= c_next;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and random checks of bit_serial_adder at WIDTH=8 and WIDTH=2 against plain a+b.
module tb_bit_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_carry, busy;
  logic [7:0] in_a, in_b, out_sum;
  logic       in_valid2, in_ready2, out_valid2, out_ready2, out_carry2, busy2;
  logic [1:0] in_a2, in_b2, out_sum2;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry),
    .busy(busy)
  );

  bit_serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_a(in_a2), .in_b(in_b2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_sum(out_sum2), .out_carry(out_carry2),
    .busy(busy2)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Wait for out_valid after an accept edge, then check latency and result.
  task automatic wait8(input logic [8:0] exp, input string tag);
    int lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, lat, 8);
    check({tag, "_sum"}, {out_carry, out_sum}, exp);
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input string tag);
    check({tag, "_rdy"}, in_ready, 1);
    in_a = a; in_b = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "_busy"}, busy, 1);
    wait8(model8(a, b), tag);
  endtask

  task automatic finish8(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_ov0"}, out_valid, 0);
    check({tag, "_idle"}, in_ready, 1);
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b, input string tag);
    int lat = 0;
    logic [2:0] exp;
    exp = {1'b0, a} + {1'b0, b};
    check({tag, "_rdy"}, in_ready2, 1);
    in_a2 = a; in_b2 = b; in_valid2 = 1'b1;
    step();
    in_valid2 = 1'b0;
    while (!out_valid2 && lat < 100) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, lat, 2);
    check({tag, "_sum"}, {out_carry2, out_sum2}, exp);
    out_ready2 = 1'b1;
    step();
    out_ready2 = 1'b0;
    check({tag, "_ov0"}, out_valid2, 0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [8:0] e;
    int results, last_v;

    rst = 1'b1; in_valid = 0; out_ready = 0; in_a = 0; in_b = 0;
    in_valid2 = 0; out_ready2 = 0; in_a2 = 0; in_b2 = 0;
    step(); step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_carry", out_carry, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    step();
    check("post_rst_ready", in_ready, 1);

    start8(8'h5A, 8'h33, "t1");
    check("t1_const", {out_carry, out_sum}, 9'h08D);
    finish8("t1");
    start8(8'hFF, 8'h01, "t2a");
    check("t2a_const", {out_carry, out_sum}, 9'h100);
    finish8("t2a");
    start8(8'h00, 8'h00, "t2b");
    finish8("t2b");
    start8(8'hFF, 8'hFF, "t3");
    check("t3_const", {out_carry, out_sum}, 9'h1FE);
    finish8("t3");

    // Backpressure with a competing operand pair offered while DONE.
    ra = 8'($urandom_range(0, 255));
    rb = 8'($urandom_range(0, 255));
    start8(ra, rb, "t4");
    in_a = 8'h11; in_b = 8'h22; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_sum", {out_carry, out_sum}, model8(ra, rb));
      check("t4_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t4_ov0", out_valid, 0);
    check("t4_rdy", in_ready, 1);
    step();
    in_valid = 1'b0;
    wait8(9'h033, "t4b");
    finish8("t4b");

    // Reset while the fourth bit is being added.
    in_a = 8'hAA; in_b = 8'h55; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t5_ov", out_valid, 0);
    check("t5_sum", out_sum, 0);
    check("t5_carry", out_carry, 0);
    check("t5_ready", in_ready, 0);
    check("t5_busy", busy, 0);
    rst = 1'b0;
    step();
    check("t5_ready_after", in_ready, 1);
    start8(8'h01, 8'h02, "t5b");
    finish8("t5b");

    // Streaming: in_valid and out_ready held high, random operands.
    exp_q.delete();
    results = 0;
    last_v = -1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 200 && results < 8; k++) begin
      if (in_ready) begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        in_a = ra; in_b = rb;
        exp_q.push_back(model8(ra, rb));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("t6_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("t6_sum", {out_carry, out_sum}, e);
        end
        if (last_v >= 0) check("t6_gap", cyc - last_v, 10);
        last_v = cyc;
        results++;
      end
      step();
    end
    check("t6_count", results, 8);
    in_valid = 1'b0;
    out_ready = 1'b0;

    op2(2'b11, 2'b11, "w2_a");
    check("w2_a_const", {out_carry2, out_sum2}, 3'b110);
    for (int k = 0; k < 4; k++) op2(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), "w2_rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
